// File: rtl/bp_dma_mem_endpoint_pkg.sv
// Shared DMA network header layout and field widths for the memory endpoint
// and the tile-side packer.
package bp_dma_mem_endpoint_pkg;

    localparam int unsigned flit_width_p = 64;
    localparam int unsigned cord_width_p = 8;
    localparam int unsigned len_width_p  = 4;
    localparam int unsigned addr_width_p = flit_width_p - 2*cord_width_p - len_width_p - 2;

    // Declared MSB first; on the wire dest_cord occupies the low bits.
    typedef struct packed {
        logic [addr_width_p-1:0] addr;
        logic [1:0]              opcode;
        logic [cord_width_p-1:0] src_cord;
        logic [len_width_p-1:0]  len;
        logic [cord_width_p-1:0] dest_cord;
    } dma_hdr_s;

    function automatic dma_hdr_s build_resp_hdr(input logic [cord_width_p-1:0] dest_cord,
                                                input logic [len_width_p-1:0]  len);
        dma_hdr_s hdr;
        hdr           = '0;
        hdr.dest_cord = dest_cord;
        hdr.len       = len;
        return hdr;
    endfunction

endpackage

// File: rtl/bp_dma_mem_endpoint.sv
// Memory-side DMA endpoint: unpacks request packets into a memory command beat
// stream and packs memory response beats into packets for the requester.
module bp_dma_mem_endpoint
    import bp_dma_mem_endpoint_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic [flit_width_p-1:0] link_data_i,
    input  logic                    link_v_i,
    output logic                    link_ready_and_o,

    output logic [flit_width_p-1:0] link_data_o,
    output logic                    link_v_o,
    input  logic                    link_ready_and_i,

    output logic [1:0]              mem_cmd_opcode_o,
    output logic [cord_width_p-1:0] mem_cmd_src_cord_o,
    output logic [addr_width_p-1:0] mem_cmd_addr_o,
    output logic [flit_width_p-1:0] mem_cmd_data_o,
    output logic                    mem_cmd_v_o,
    output logic                    mem_cmd_last_o,
    input  logic                    mem_cmd_ready_and_i,

    input  logic [cord_width_p-1:0] mem_resp_dest_cord_i,
    input  logic [len_width_p-1:0]  mem_resp_len_i,
    input  logic [flit_width_p-1:0] mem_resp_data_i,
    input  logic                    mem_resp_v_i,
    output logic                    mem_resp_ready_and_o
);

    typedef enum logic [1:0] {e_rx_header, e_rx_data, e_rx_hold_zero} rx_state_e;
    typedef enum logic       {e_tx_header, e_tx_data} tx_state_e;

    rx_state_e               rx_state;
    tx_state_e               tx_state;
    logic [len_width_p-1:0]  rx_cnt;
    logic [len_width_p-1:0]  tx_cnt;
    logic [1:0]              rx_opcode;
    logic [cord_width_p-1:0] rx_src_cord;
    logic [addr_width_p-1:0] rx_addr;
    dma_hdr_s                rx_hdr;
    logic                    tx_fire;

    assign rx_hdr  = dma_hdr_s'(link_data_i);
    assign tx_fire = mem_resp_v_i & link_ready_and_i;

    // RX: capture header fields, then count payload handshakes down to the last beat.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_state    <= e_rx_header;
            rx_cnt      <= '0;
            rx_opcode   <= '0;
            rx_src_cord <= '0;
            rx_addr     <= '0;
        end else begin
            case (rx_state)
                e_rx_header: begin
                    if (link_v_i) begin
                        rx_opcode   <= rx_hdr.opcode;
                        rx_src_cord <= rx_hdr.src_cord;
                        rx_addr     <= rx_hdr.addr;
                        rx_cnt      <= rx_hdr.len;
                        rx_state    <= (rx_hdr.len == '0) ? e_rx_hold_zero : e_rx_data;
                    end
                end
                e_rx_data: begin
                    if (link_v_i && mem_cmd_ready_and_i) begin
                        rx_cnt <= rx_cnt - len_width_p'(1);
                        if (rx_cnt == len_width_p'(1)) rx_state <= e_rx_header;
                    end
                end
                e_rx_hold_zero: begin
                    if (mem_cmd_ready_and_i) rx_state <= e_rx_header;
                end
                default: rx_state <= e_rx_header;
            endcase
        end
    end

    // RX outputs: payload passes straight through; zero-length packets get one synthetic beat.
    always_comb begin
        link_ready_and_o = 1'b0;
        mem_cmd_v_o      = 1'b0;
        mem_cmd_data_o   = '0;
        mem_cmd_last_o   = 1'b0;
        case (rx_state)
            e_rx_header: link_ready_and_o = 1'b1;
            e_rx_data: begin
                mem_cmd_v_o      = link_v_i;
                mem_cmd_data_o   = link_data_i;
                mem_cmd_last_o   = (rx_cnt == len_width_p'(1));
                link_ready_and_o = mem_cmd_ready_and_i;
            end
            e_rx_hold_zero: begin
                mem_cmd_v_o    = 1'b1;
                mem_cmd_last_o = 1'b1;
            end
            default: link_ready_and_o = 1'b0;
        endcase
    end

    assign mem_cmd_opcode_o   = rx_opcode;
    assign mem_cmd_src_cord_o = rx_src_cord;
    assign mem_cmd_addr_o     = rx_addr;

    // TX: a nonzero-length header leaves the response beat in place for the first payload flit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_state <= e_tx_header;
            tx_cnt   <= '0;
        end else begin
            case (tx_state)
                e_tx_header: begin
                    if (tx_fire && (mem_resp_len_i != '0)) begin
                        tx_cnt   <= mem_resp_len_i;
                        tx_state <= e_tx_data;
                    end
                end
                e_tx_data: begin
                    if (tx_fire) begin
                        tx_cnt <= tx_cnt - len_width_p'(1);
                        if (tx_cnt == len_width_p'(1)) tx_state <= e_tx_header;
                    end
                end
                default: tx_state <= e_tx_header;
            endcase
        end
    end

    always_comb begin
        link_v_o             = mem_resp_v_i;
        link_data_o          = mem_resp_data_i;
        mem_resp_ready_and_o = link_ready_and_i;
        if (tx_state == e_tx_header) begin
            link_data_o          = flit_width_p'(build_resp_hdr(mem_resp_dest_cord_i, mem_resp_len_i));
            mem_resp_ready_and_o = link_ready_and_i & (mem_resp_len_i == '0);
        end
    end

endmodule

// File: tb/tb_bp_dma_mem_endpoint.sv
// Randomized bench for bp_dma_mem_endpoint against a packet-level reference model.
module tb_bp_dma_mem_endpoint;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [63:0] link_data_i = '0;
    logic        link_v_i = 1'b0;
    logic        link_ready_and_o;
    logic [63:0] link_data_o;
    logic        link_v_o;
    logic        link_ready_and_i = 1'b0;
    logic [1:0]  mem_cmd_opcode_o;
    logic [7:0]  mem_cmd_src_cord_o;
    logic [41:0] mem_cmd_addr_o;
    logic [63:0] mem_cmd_data_o;
    logic        mem_cmd_v_o;
    logic        mem_cmd_last_o;
    logic        mem_cmd_ready_and_i = 1'b0;
    logic [7:0]  mem_resp_dest_cord_i = '0;
    logic [3:0]  mem_resp_len_i = '0;
    logic [63:0] mem_resp_data_i = '0;
    logic        mem_resp_v_i = 1'b0;
    logic        mem_resp_ready_and_o;

    bp_dma_mem_endpoint dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .link_data_i(link_data_i), .link_v_i(link_v_i), .link_ready_and_o(link_ready_and_o),
        .link_data_o(link_data_o), .link_v_o(link_v_o), .link_ready_and_i(link_ready_and_i),
        .mem_cmd_opcode_o(mem_cmd_opcode_o), .mem_cmd_src_cord_o(mem_cmd_src_cord_o),
        .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_data_o(mem_cmd_data_o),
        .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_last_o(mem_cmd_last_o),
        .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
        .mem_resp_dest_cord_i(mem_resp_dest_cord_i), .mem_resp_len_i(mem_resp_len_i),
        .mem_resp_data_i(mem_resp_data_i), .mem_resp_v_i(mem_resp_v_i),
        .mem_resp_ready_and_o(mem_resp_ready_and_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0]        dest;
        logic [3:0]        len;
        logic [15:0][63:0] data;
    } resp_t;

    int checks = 0;
    int failures = 0;

    logic [63:0]  rx_flits[$];
    logic [127:0] exp_cmd[$];
    resp_t        resp_q[$];
    logic [63:0]  exp_link[$];
    int           tx_idx = 0;
    int           resp_hs = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [41:0] addr, input logic [1:0] op,
                                        input logic [7:0] src, input logic [3:0] len,
                                        input logic [7:0] dest);
        return {addr, op, src, len, dest};
    endfunction

    function automatic logic [127:0] beat(input logic [1:0] op, input logic [7:0] src,
                                          input logic [41:0] addr, input logic [63:0] data,
                                          input logic last);
        return 128'({op, src, addr, data, last});
    endfunction

    // A request packet yields len beats, or one zero-data beat when len is 0.
    task automatic add_rx(input logic [1:0] op, input logic [7:0] src,
                          input logic [41:0] addr, input logic [3:0] len);
        logic [63:0] d;
        rx_flits.push_back(hdr(addr, op, src, len, 8'($urandom)));
        if (len == 0) exp_cmd.push_back(beat(op, src, addr, 64'd0, 1'b1));
        for (int i = 0; i < int'(len); i++) begin
            d = {$urandom, $urandom};
            rx_flits.push_back(d);
            exp_cmd.push_back(beat(op, src, addr, d, i == int'(len) - 1));
        end
    endtask

    // A response becomes a header (src/opcode/addr zero) followed by its len payload flits.
    task automatic add_tx(input logic [7:0] dest, input logic [3:0] len);
        resp_t r;
        r.dest = dest;
        r.len  = len;
        for (int i = 0; i < 16; i++) r.data[i] = {$urandom, $urandom};
        resp_q.push_back(r);
        exp_link.push_back(hdr(42'd0, 2'd0, 8'd0, len, dest));
        for (int i = 0; i < int'(len); i++) exp_link.push_back(r.data[i]);
    endtask

    function automatic logic [3:0] rand_len();
        if ($urandom_range(0, 3) == 0) return 4'd0;
        if ($urandom_range(0, 4) == 0) return 4'd15;
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic bit all_done();
        return rx_flits.size() == 0 && exp_cmd.size() == 0 &&
               resp_q.size() == 0 && exp_link.size() == 0;
    endfunction

    // Drives both sides with the given valid/ready percentages until all queues drain.
    task automatic run(input int max_cyc, input int pv_rx, input int pr_cmd,
                       input int pv_tx, input int pr_link, output int cyc);
        cyc = 0;
        while (!all_done() && cyc < max_cyc) begin
            @(negedge clk_i);
            cyc++;
            link_v_i            = rx_flits.size() > 0 && $urandom_range(1, 100) <= pv_rx;
            link_data_i         = link_v_i ? rx_flits[0] : {$urandom, $urandom};
            mem_cmd_ready_and_i = $urandom_range(1, 100) <= pr_cmd;
            mem_resp_v_i        = resp_q.size() > 0 && $urandom_range(1, 100) <= pv_tx;
            if (mem_resp_v_i) begin
                mem_resp_dest_cord_i = resp_q[0].dest;
                mem_resp_len_i       = resp_q[0].len;
                mem_resp_data_i      = (resp_q[0].len != 0) ? resp_q[0].data[tx_idx] : {$urandom, $urandom};
            end else begin
                mem_resp_dest_cord_i = 8'($urandom);
                mem_resp_len_i       = 4'($urandom);
                mem_resp_data_i      = {$urandom, $urandom};
            end
            link_ready_and_i = $urandom_range(1, 100) <= pr_link;
            #1;
            if (link_v_i && link_ready_and_o) void'(rx_flits.pop_front());
            if (mem_cmd_v_o && mem_cmd_ready_and_i) begin
                if (exp_cmd.size() == 0) chk("cmd_extra", 128'd1, 128'd0);
                else chk("cmd_beat", beat(mem_cmd_opcode_o, mem_cmd_src_cord_o, mem_cmd_addr_o,
                                          mem_cmd_data_o, mem_cmd_last_o), exp_cmd.pop_front());
            end
            if (!mem_resp_v_i) chk("tx_v_idle", 128'(link_v_o), 128'd0);
            if (link_v_o && link_ready_and_i) begin
                if (exp_link.size() == 0) chk("tx_extra", 128'd1, 128'd0);
                else chk("tx_flit", 128'(link_data_o), 128'(exp_link.pop_front()));
            end
            if (mem_resp_v_i && mem_resp_ready_and_o) begin
                resp_hs++;
                tx_idx++;
                if (tx_idx >= ((resp_q[0].len == 0) ? 1 : int'(resp_q[0].len))) begin
                    void'(resp_q.pop_front());
                    tx_idx = 0;
                end
            end
        end
        chk("drained", 128'(all_done()), 128'd1);
        @(negedge clk_i);
        link_v_i            = 1'b0;
        mem_resp_v_i        = 1'b0;
        mem_cmd_ready_and_i = 1'b0;
        link_ready_and_i    = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [63:0] pay [4];

        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_link_ready", 128'(link_ready_and_o), 128'd1);
        chk("rst_cmd_v", 128'(mem_cmd_v_o), 128'd0);
        chk("rst_link_v", 128'(link_v_o), 128'd0);
        chk("rst_addr", 128'(mem_cmd_addr_o), 128'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Zero-length read
        add_rx(2'd0, 8'd3, 42'h1234, 4'd0);
        run(20, 100, 100, 100, 100, cyc);
        chk("read0_cycles", 128'(cyc), 128'd2);
        #1;
        chk("read0_ready_after", 128'(link_ready_and_o), 128'd1);

        // Write len=4 with toggling command ready
        add_rx(2'd1, 8'd7, 42'h3_0000_0040, 4'd4);
        run(200, 100, 50, 100, 100, cyc);

        // Back-to-back len=1 then len=0 at full rate: no bubble
        add_rx(2'd1, 8'd2, 42'h10, 4'd1);
        add_rx(2'd0, 8'd2, 42'h20, 4'd0);
        run(20, 100, 100, 100, 100, cyc);
        chk("b2b_cycles", 128'(cyc), 128'd4);

        // Response header held while the network stalls
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            mem_resp_v_i = 1'b1; mem_resp_dest_cord_i = 8'd5; mem_resp_len_i = 4'd2;
            mem_resp_data_i = {$urandom, $urandom}; link_ready_and_i = 1'b0;
            #1;
            chk("hold_v", 128'(link_v_o), 128'd1);
            chk("hold_hdr", 128'(link_data_o), 128'(hdr(42'd0, 2'd0, 8'd0, 4'd2, 8'd5)));
            chk("hold_ready", 128'(mem_resp_ready_and_o), 128'd0);
        end
        resp_hs = 0;
        add_tx(8'd5, 4'd2);
        run(20, 100, 100, 100, 100, cyc);
        chk("hold_cycles", 128'(cyc), 128'd3);
        chk("hold_pulses", 128'(resp_hs), 128'd2);

        // Simultaneous RX and TX of length 3
        add_rx(2'd2, 8'd9, 42'h777, 4'd3);
        add_tx(8'd9, 4'd3);
        run(20, 100, 100, 100, 100, cyc);
        chk("dual_cycles", 128'(cyc), 128'd4);

        // Maximum length both ways
        add_rx(2'd1, 8'd1, 42'h5, 4'd15);
        add_tx(8'd1, 4'd15);
        run(50, 100, 100, 100, 100, cyc);
        chk("max_cycles", 128'(cyc), 128'd16);

        // Reset after 2 of 4 payload flits
        for (int i = 0; i < 4; i++) pay[i] = {$urandom, $urandom};
        mem_cmd_ready_and_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            link_v_i    = 1'b1;
            link_data_i = (i == 0) ? hdr(42'h99, 2'd1, 8'd4, 4'd4, 8'd0) : pay[i-1];
            #1;
            chk("pre_rst_ready", 128'(link_ready_and_o), 128'd1);
            if (i > 0) chk("pre_rst_beat", 128'({mem_cmd_v_o, mem_cmd_data_o}), 128'({1'b1, pay[i-1]}));
        end
        @(negedge clk_i);
        link_data_i = pay[2];
        reset_i     = 1'b1;
        #1;
        chk("async_rst_ready", 128'(link_ready_and_o), 128'd1);
        chk("async_rst_cmd_v", 128'(mem_cmd_v_o), 128'd0);
        chk("async_rst_fields", 128'({mem_cmd_addr_o, mem_cmd_src_cord_o, mem_cmd_opcode_o}), 128'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        link_v_i = 1'b0;
        mem_cmd_ready_and_i = 1'b0;
        add_rx(2'd3, 8'd6, 42'hABC, 4'd2);
        run(50, 70, 70, 100, 100, cyc);

        // Randomized traffic on both sides
        for (int p = 0; p < 30; p++) begin
            add_rx(2'($urandom), 8'($urandom), 42'({$urandom, $urandom}), rand_len());
            add_tx(8'($urandom), rand_len());
        end
        run(20000, 60, 70, 65, 75, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
